// File: rtl/mem_lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes, FSM states
// and the access-size decode used by both the lane aligner and the FSM.
package mem_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    // Undefined load/store encodings collapse to a full-word access.
    function automatic acc_size_e access_size(input logic [2:0] f3, input logic is_store);
        acc_size_e sz;
        sz = SZ_W;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_B;
                F3_SH:   sz = SZ_H;
                F3_SW:   sz = SZ_W;
                default: sz = SZ_W;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_B;
                F3_LH, F3_LHU: sz = SZ_H;
                F3_LW:         sz = SZ_W;
                default:       sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Word-aligned data-bus with a req/ack handshake between the LSU (master)
// and memory (slave).
interface mem_lsu_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store data replication and strobes, load lane
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic        is_store_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    acc_size_e   size;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata_i[8*gi +: 8];
        end
    endgenerate

    assign size     = access_size(funct3_i, is_store_i);
    assign sel_byte = rbyte[offset_i];
    assign sel_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        wdata_o    = sdata_i;
        wstrb_o    = 4'b0000;
        ldata_o    = rdata_i;
        misalign_o = 1'b0;

        case (size)
            SZ_B:    misalign_o = 1'b0;
            SZ_H:    misalign_o = offset_i[0];
            default: misalign_o = |offset_i;
        endcase

        if (is_store_i) begin
            case (size)
                SZ_B: begin
                    wdata_o = {4{sdata_i[7:0]}};
                    wstrb_o = 4'b0001 << offset_i;
                end
                SZ_H: begin
                    wdata_o = {2{sdata_i[15:0]}};
                    wstrb_o = 4'b0011 << offset_i;
                end
                default: begin
                    wdata_o = sdata_i;
                    wstrb_o = 4'b1111;
                end
            endcase
        end

        case (funct3_i)
            F3_LB:   ldata_o = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  ldata_o = {24'd0, sel_byte};
            F3_LH:   ldata_o = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  ldata_o = {16'd0, sel_half};
            F3_LW:   ldata_o = rdata_i;
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store stage: turns execute-stage memory requests into one bus
// transaction each, stalls until ack, and registers the write-back fields.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic        mem_r_ena_i,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_r_addr_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic        reg_w_ena_i,
    input  logic [4:0]  reg_w_addr_i,
    input  logic [31:0] reg_w_data_i,
    mem_lsu_if.master   bus,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        reg_w_ena_o,
    output logic [4:0]  reg_w_addr_o,
    output logic [31:0] reg_w_data_o
);

    lsu_state_e  state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwe_q, hwe_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [3:0]  hwstrb_q, hwstrb_d;
    logic [2:0]  hfunct3_q, hfunct3_d;
    logic [4:0]  hrd_q, hrd_d;
    logic [1:0]  hoff_q, hoff_d;
    logic        misalign_q, misalign_d;
    logic        wb_ena_q, wb_ena_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        mem_op;
    logic        busy;
    logic [31:0] req_addr;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic        al_store;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_ldata;
    logic        al_mis;
    logic        unused_inst;

    assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

    assign mem_op   = mem_r_ena_i | mem_w_ena_i;
    assign busy     = (state_q == LSU_BUSY);
    assign req_addr = mem_w_ena_i ? mem_w_addr_i : mem_r_addr_i;

    // Once BUSY the aligner must see only the latched copy of the request.
    assign al_funct3 = busy ? hfunct3_q : inst_i[14:12];
    assign al_off    = busy ? hoff_q    : req_addr[1:0];
    assign al_store  = busy ? hwe_q     : mem_w_ena_i;

    lsu_align u_align (
        .funct3_i   (al_funct3),
        .offset_i   (al_off),
        .is_store_i (al_store),
        .sdata_i    (reg_w_data_i),
        .rdata_i    (bus.bus_rdata_i),
        .wdata_o    (al_wdata),
        .wstrb_o    (al_wstrb),
        .ldata_o    (al_ldata),
        .misalign_o (al_mis)
    );

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hwe_d      = hwe_q;
        hwdata_d   = hwdata_q;
        hwstrb_d   = hwstrb_q;
        hfunct3_d  = hfunct3_q;
        hrd_d      = hrd_q;
        hoff_d     = hoff_q;
        misalign_d = 1'b0;
        wb_ena_d   = wb_ena_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        stall_o    = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (!mem_op) begin
                    wb_ena_d  = reg_w_ena_i && (reg_w_addr_i != 5'd0);
                    wb_addr_d = reg_w_addr_i;
                    wb_data_d = reg_w_data_i;
                end else if (al_mis) begin
                    misalign_d = 1'b1;
                    wb_ena_d   = 1'b0;
                end else begin
                    stall_o   = 1'b1;
                    wb_ena_d  = 1'b0;
                    state_d   = LSU_BUSY;
                    haddr_d   = {req_addr[31:2], 2'b00};
                    hwe_d     = mem_w_ena_i;
                    hwdata_d  = al_wdata;
                    hwstrb_d  = al_wstrb;
                    hfunct3_d = inst_i[14:12];
                    hrd_d     = reg_w_addr_i;
                    hoff_d    = req_addr[1:0];
                end
            end
            LSU_BUSY: begin
                if (bus.bus_ack_i) begin
                    state_d = LSU_IDLE;
                    if (!hwe_q) begin
                        wb_ena_d  = (hrd_q != 5'd0);
                        wb_addr_d = hrd_q;
                        wb_data_d = al_ldata;
                    end else begin
                        wb_ena_d = 1'b0;
                    end
                end else begin
                    stall_o  = 1'b1;
                    wb_ena_d = 1'b0;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            haddr_q    <= '0;
            hwe_q      <= 1'b0;
            hwdata_q   <= '0;
            hwstrb_q   <= '0;
            hfunct3_q  <= '0;
            hrd_q      <= '0;
            hoff_q     <= '0;
            misalign_q <= 1'b0;
            wb_ena_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hwe_q      <= hwe_d;
            hwdata_q   <= hwdata_d;
            hwstrb_q   <= hwstrb_d;
            hfunct3_q  <= hfunct3_d;
            hrd_q      <= hrd_d;
            hoff_q     <= hoff_d;
            misalign_q <= misalign_d;
            wb_ena_q   <= wb_ena_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.bus_req_o   = busy;
    assign bus.bus_we_o    = hwe_q;
    assign bus.bus_addr_o  = haddr_q;
    assign bus.bus_wdata_o = hwdata_q;
    assign bus.bus_wstrb_o = hwstrb_q;

    assign misalign_o   = misalign_q;
    assign reg_w_ena_o  = wb_ena_q;
    assign reg_w_addr_o = wb_addr_q;
    assign reg_w_data_o = wb_data_q;

endmodule
